icache_refill: RTL and testbench
================================

Name: icache_refill

Overview:
- Direct-mapped instruction cache in the IF stage, with a line-refill state machine toward main memory.
- Supplies the instruction for the current PC and drives o_ICache_Miss to the stall controller.
- While that signal is high, the stall controller freezes the PC and flushes IF/ID.
- On a miss, the block fetches the whole line from memory over a valid-beat handshake and then resumes hitting.

Parameters:
- ADDR_W, 32, byte address width of the PC and the memory address.
- DATA_W, 32, instruction/word width.
- LINE_WORDS, 4, words per cache line; must be a power of two, at least 2.
- NUM_LINES, 16, number of lines; must be a power of two, at least 2.

Ports:
- i_Clk  in  1  system clock, rising edge.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_PC  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- i_Read  in  1  fetch request this cycle.
- i_Invalidate  in  1  clear all valid bits (fence.i / self-modifying code).
- o_Instr  out  DATA_W  instruction word; meaningful only when i_Read=1 and o_ICache_Miss=0.
- o_ICache_Miss  out  1  fetch not satisfied this cycle; to the stall controller.
- o_Mem_Req  out  1  refill request; held high for the whole refill.
- o_Mem_Addr  out  ADDR_W  byte address of the requested word.
- i_Mem_Valid  in  1  memory returns one word this cycle.
- i_Mem_Data  in  DATA_W  returned word.

Behaviour:
- Address split:
  - offset = log2(LINE_WORDS)+2 low bits (word select = PC[offset-1:2]);
  - index = next log2(NUM_LINES) bits;
  - tag = the remaining high bits.
- Storage: data array NUM_LINES*LINE_WORDS words; tag array; valid bit per line.
- Arrays are read asynchronously and written on the clock edge.
- Hit (combinational) = state IDLE, valid[index], tag match. A hit sets o_Instr the same cycle with zero added latency.
- o_ICache_Miss = i_Read & ~hit. It is also forced to 1 in any state other than IDLE when i_Read=1. When i_Read=0 it is 0 and no refill starts.
- FSM states: IDLE, REFILL, FILLED.
- IDLE:
  - Transition to REFILL on i_Read & ~hit.
  - On that transition, latch the line base (PC with offset bits zeroed) and the index/tag, and clear the beat counter.
- REFILL:
  - o_Mem_Req=1.
  - o_Mem_Addr = latched base + 4*beat_count.
  - Each cycle with i_Mem_Valid=1: write i_Mem_Data to the data array at [latched index][beat_count], then increment beat_count.
  - On the beat where beat_count = LINE_WORDS-1: write the tag, set valid (unless squashed, see below), and go to FILLED.
  - i_Mem_Valid outside REFILL is ignored.
- FILLED: one bubble cycle. o_Mem_Req=0, miss is still reported, and the FSM returns to IDLE. The next cycle hits if the PC still maps to the line.
- Miss-to-instruction latency: 1 request cycle + LINE_WORDS beats (plus any memory wait cycles) + 1 FILLED cycle.
- PC change during a refill: the refill always completes to the latched line. The new PC is evaluated only after returning to IDLE and may start another refill.
- i_Invalidate:
  - Clears all valid bits on the next edge.
  - If asserted during REFILL, set a squash flag: the refill completes but the line is not marked valid. The squash flag clears on entering IDLE.
  - If asserted in the same cycle as the final beat, the line is not marked valid.
- Beat counter width is log2(LINE_WORDS). It wraps only at refill completion and never exceeds LINE_WORDS-1.
- Reset (asynchronous, at any time including mid-refill):
  - state=IDLE, o_Mem_Req=0, o_Mem_Addr=0, beat_count=0, squash=0;
  - all valid bits=0; o_ICache_Miss=0 while i_Read=0.
  - Data and tag arrays are not reset.
  - A pending refill is dropped, and later memory beats are ignored.

Optional Feature:
- ICACHE_STATS_EN defined: adds outputs o_Hit_Count and o_Miss_Count, each 32 bits.
  - Hit counter: +1 on each IDLE cycle with i_Read & hit.
  - Miss counter: +1 on each IDLE->REFILL transition.
  - Both saturate at 0xFFFFFFFF, are reset to 0 by i_Reset_n, and are not cleared by i_Invalidate.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss:
  - Stimulus: reset, then i_Read=1, PC=0x100, memory returns words 0xA0..0xA3 on consecutive cycles.
  - Response: o_ICache_Miss=1 for 6 cycles; o_Mem_Addr steps 0x100/0x104/0x108/0x10C; cycle 7 hits with o_Instr=0xA0.
- Same-line hits:
  - Stimulus: after the cold miss, PC=0x104, 0x108, 0x10C.
  - Response: o_ICache_Miss=0 each cycle; o_Instr=0xA1, 0xA2, 0xA3; o_Mem_Req=0.
- Conflict:
  - Stimulus: PC=0x200 (same index, different tag for 16x4 lines at the default parameters).
  - Response: a refill starts at 0x200; a later PC=0x100 misses again.
- Memory wait states:
  - Stimulus: i_Mem_Valid only every third cycle.
  - Response: o_Mem_Req stays high, beat addresses advance only on valid beats, data is correct after FILLED.
- Invalidate during refill:
  - Stimulus: assert i_Invalidate on beat 2 of a refill to 0x300.
  - Response: the refill completes and returns to IDLE; the next PC=0x300 misses again.
- Reset mid-refill:
  - Stimulus: drop i_Reset_n after beat 1.
  - Response: o_Mem_Req=0 immediately, all lines invalid, the following fetch misses.
  - With ICACHE_STATS_EN: counters read 0.

Source files
------------

// File: rtl/icache_refill_if.sv
// Memory-side refill bus of the instruction cache.
// master = cache (issues requests), slave = memory (returns beats).
interface icache_refill_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              o_Mem_Req;
   logic [ADDR_W-1:0] o_Mem_Addr;
   logic              i_Mem_Valid;
   logic [DATA_W-1:0] i_Mem_Data;

   modport master (
      output o_Mem_Req,
      output o_Mem_Addr,
      input  i_Mem_Valid,
      input  i_Mem_Data
   );

   modport slave (
      input  o_Mem_Req,
      input  o_Mem_Addr,
      output i_Mem_Valid,
      output i_Mem_Data
   );
endinterface

// File: rtl/icache_refill.sv
// Direct-mapped IF-stage instruction cache with a line-refill FSM.
// Define ICACHE_STATS_EN to add saturating hit/miss counters.
module icache_refill #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 4,
   parameter int NUM_LINES  = 16
) (
   input  logic              i_Clk,
   input  logic              i_Reset_n,
   input  logic [ADDR_W-1:0] i_PC,
   input  logic              i_Read,
   input  logic              i_Invalidate,
   icache_refill_if.master   mem,
   output logic [DATA_W-1:0] o_Instr,
   output logic              o_ICache_Miss
`ifdef ICACHE_STATS_EN
   ,output logic [31:0]      o_Hit_Count
   ,output logic [31:0]      o_Miss_Count
`endif
);

   localparam int W_W   = $clog2(LINE_WORDS);
   localparam int OFF_W = W_W + 2;
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
   localparam int ENT_N = NUM_LINES * LINE_WORDS;

   localparam logic [W_W-1:0] LAST_BEAT = W_W'(LINE_WORDS - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_REFILL = 2'd1;
   localparam logic [1:0] S_FILLED = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [ADDR_W-1:0]    base_q, base_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [TAG_W-1:0]     tag_q, tag_d;
   logic [W_W-1:0]       beat_q, beat_d;
   logic                 squash_q, squash_d;
   logic [NUM_LINES-1:0] valid_q, valid_d;

   logic [DATA_W-1:0] data_mem [ENT_N];
   logic [TAG_W-1:0]  tag_mem  [NUM_LINES];

   logic [W_W-1:0]   pc_wsel;
   logic [IDX_W-1:0] pc_idx;
   logic [TAG_W-1:0] pc_tag;
   logic             st_idle;
   logic             st_refill;
   logic             st_filled;
   logic             hit;
   logic             start;
   logic             beat_we;
   logic             last_beat;
   logic             unused_pc_lsb;

   assign pc_wsel = i_PC[OFF_W-1:2];
   assign pc_idx  = i_PC[OFF_W+IDX_W-1:OFF_W];
   assign pc_tag  = i_PC[ADDR_W-1:OFF_W+IDX_W];

   assign unused_pc_lsb = ^i_PC[1:0];

   assign st_idle   = (state_q == S_IDLE);
   assign st_refill = (state_q == S_REFILL);
   assign st_filled = (state_q == S_FILLED);

   // Zero-latency lookup; miss is forced whenever the FSM is busy.
   always_comb begin
      o_Instr = data_mem[{pc_idx, pc_wsel}];
      hit = st_idle
          & valid_q[pc_idx]
          & (tag_mem[pc_idx] == pc_tag);
      o_ICache_Miss = i_Read & ~hit;
      start = st_idle & i_Read & ~hit;
      beat_we = st_refill & mem.i_Mem_Valid;
      last_beat = beat_we & (beat_q == LAST_BEAT);
   end

   // Refill bus: address walks the latched line one word per beat.
   always_comb begin
      mem.o_Mem_Req  = st_refill;
      mem.o_Mem_Addr = '0;
      if (st_refill) begin
         mem.o_Mem_Addr = base_q + ADDR_W'({beat_q, 2'b00});
      end
   end

   // FSM next state and refill bookkeeping.
   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      idx_d    = idx_q;
      tag_d    = tag_q;
      beat_d   = beat_q;
      squash_d = squash_q;
      unique case (1'b1)
         st_idle: begin
            squash_d = 1'b0;
            if (start) begin
               state_d = S_REFILL;
               base_d  = {i_PC[ADDR_W-1:OFF_W], OFF_W'(0)};
               idx_d   = pc_idx;
               tag_d   = pc_tag;
               beat_d  = '0;
            end
         end
         st_refill: begin
            if (i_Invalidate) begin
               squash_d = 1'b1;
            end
            if (beat_we) begin
               beat_d = beat_q + 1'b1;
            end
            if (last_beat) begin
               state_d = S_FILLED;
            end
         end
         st_filled: begin
            state_d  = S_IDLE;
            squash_d = 1'b0;
         end
         default: begin
            state_d  = S_IDLE;
            squash_d = 1'b0;
            beat_d   = '0;
         end
      endcase
   end

   // Valid bits: invalidate wins over a completing (or squashed) fill.
   always_comb begin
      valid_d = valid_q;
      if (i_Invalidate) begin
         valid_d = '0;
      end else if (last_beat && !squash_q) begin
         valid_d[idx_q] = 1'b1;
      end
   end

   // Control state, cleared asynchronously.
   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q  <= S_IDLE;
         base_q   <= '0;
         idx_q    <= '0;
         tag_q    <= '0;
         beat_q   <= '0;
         squash_q <= 1'b0;
         valid_q  <= '0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         idx_q    <= idx_d;
         tag_q    <= tag_d;
         beat_q   <= beat_d;
         squash_q <= squash_d;
         valid_q  <= valid_d;
      end
   end

   // Data and tag arrays hold no reset; valid bits gate their use.
   always_ff @(posedge i_Clk) begin
      if (beat_we) begin
         data_mem[{idx_q, beat_q}] <= mem.i_Mem_Data;
      end
      if (last_beat) begin
         tag_mem[idx_q] <= tag_q;
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   // Saturating event counters; untouched by invalidate.
   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (st_idle && i_Read && hit && !(&hit_cnt_q)) begin
         hit_cnt_d = hit_cnt_q + 32'd1;
      end
      if (start && !(&miss_cnt_q)) begin
         miss_cnt_d = miss_cnt_q + 32'd1;
      end
   end

   // Counter registers.
   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign o_Hit_Count  = hit_cnt_q;
   assign o_Miss_Count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_refill.sv
// Randomized bench for icache_refill against a line-level cache model.
// Build with ICACHE_STATS_EN to also check the counters.
module tb_icache_refill;

   localparam int LW = 4;
   localparam int NL = 16;

   logic        i_Clk = 1'b0;
   logic        i_Reset_n;
   logic [31:0] i_PC;
   logic        i_Read;
   logic        i_Invalidate;
   logic [31:0] o_Instr;
   logic        o_ICache_Miss;
`ifdef ICACHE_STATS_EN
   logic [31:0] o_Hit_Count;
   logic [31:0] o_Miss_Count;
`endif

   icache_refill_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

   icache_refill #(
      .ADDR_W(32), .DATA_W(32),
      .LINE_WORDS(LW), .NUM_LINES(NL)
   ) dut (
      .i_Clk        (i_Clk),
      .i_Reset_n    (i_Reset_n),
      .i_PC         (i_PC),
      .i_Read       (i_Read),
      .i_Invalidate (i_Invalidate),
      .mem          (mem_if),
      .o_Instr      (o_Instr),
      .o_ICache_Miss(o_ICache_Miss)
`ifdef ICACHE_STATS_EN
      ,.o_Hit_Count (o_Hit_Count)
      ,.o_Miss_Count(o_Miss_Count)
`endif
   );

   always #5 i_Clk = ~i_Clk;

   int n_chk  = 0;
   int n_fail = 0;

   bit          m_valid [NL];
   logic [23:0] m_tag   [NL];
   longint      m_hits   = 0;
   longint      m_misses = 0;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] memw(input logic [31:0] a);
      if (a >= 32'h100 && a < 32'h110)
         return 32'hA0 + ((a - 32'h100) >> 2);
      return {a[15:0] ^ 16'h5A5A, a[15:0]};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
   endtask

   task automatic step();
      @(posedge i_Clk);
      #1;
   endtask

   // wmode: 0 back-to-back, 1 every third cycle, 2 random waits
   task automatic fetch(input logic [31:0] pc,
                        input int wmode,
                        input int inv_beat);
      int idx, beats, cyc;
      logic [23:0] tg;
      logic [31:0] base, a;
      bit v, invd;
      idx  = int'(pc[7:4]);
      tg   = pc[31:8];
      base = {pc[31:4], 4'h0};
      i_PC = pc;
      i_Read = 1'b1;
      #1;
      if (m_valid[idx] && m_tag[idx] == tg) begin
         chk("hit_miss", o_ICache_Miss, 0);
         chk("hit_instr", o_Instr, memw(pc));
         chk("hit_req", mem_if.o_Mem_Req, 0);
         m_hits++;
         step();
         return;
      end
      chk("miss_flag", o_ICache_Miss, 1);
      chk("miss_req0", mem_if.o_Mem_Req, 0);
      m_misses++;
      step();
      beats = 0;
      cyc = 0;
      invd = 1'b0;
      while (beats < LW && cyc < 100) begin
         chk("refill_req", mem_if.o_Mem_Req, 1);
         chk("refill_addr", mem_if.o_Mem_Addr,
             base + 32'(4 * beats));
         chk("refill_miss", o_ICache_Miss, 1);
         case (wmode)
            0: v = 1'b1;
            1: v = (cyc % 3 == 2);
            default: v = ($urandom_range(0, 2) == 0);
         endcase
         a = base + 32'(4 * beats);
         mem_if.i_Mem_Valid = v;
         mem_if.i_Mem_Data = v ? memw(a) : 32'hDEADBEEF;
         i_Invalidate = v && (beats == inv_beat);
         if (i_Invalidate) invd = 1'b1;
         if (cyc > 0) i_PC = {22'd0, 6'($urandom), 4'h0};
         step();
         mem_if.i_Mem_Valid = 1'b0;
         i_Invalidate = 1'b0;
         if (v) beats++;
         cyc++;
      end
      chk("refill_done", beats, LW);
      chk("filled_miss", o_ICache_Miss, 1);
      chk("filled_req", mem_if.o_Mem_Req, 0);
      if (invd) begin
         model_clear();
      end else begin
         m_valid[idx] = 1'b1;
         m_tag[idx] = tg;
      end
      step();
   endtask

   task automatic idle_cycle();
      i_Read = 1'b0;
      i_PC = {22'd0, 6'($urandom), 4'h0};
      mem_if.i_Mem_Valid = 1'($urandom);
      mem_if.i_Mem_Data = $urandom;
      #1;
      chk("noread_miss", o_ICache_Miss, 0);
      step();
      chk("noread_req", mem_if.o_Mem_Req, 0);
      mem_if.i_Mem_Valid = 1'b0;
   endtask

   task automatic inval_cycle();
      i_Read = 1'b0;
      i_Invalidate = 1'b1;
      step();
      i_Invalidate = 1'b0;
      model_clear();
   endtask

   task automatic chk_stats();
`ifdef ICACHE_STATS_EN
      chk("hit_count", o_Hit_Count, m_hits);
      chk("miss_count", o_Miss_Count, m_misses);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] pc;
      i_Reset_n = 1'b0;
      i_PC = '0;
      i_Read = 1'b0;
      i_Invalidate = 1'b0;
      mem_if.i_Mem_Valid = 1'b0;
      mem_if.i_Mem_Data = '0;
      model_clear();
      #2;
      chk("rst_req", mem_if.o_Mem_Req, 0);
      chk("rst_addr", mem_if.o_Mem_Addr, 0);
      chk("rst_miss", o_ICache_Miss, 0);
      chk_stats();
      repeat (2) @(posedge i_Clk);
      @(negedge i_Clk);
      i_Reset_n = 1'b1;
      step();

      fetch(32'h100, 0, -1);
      fetch(32'h104, 0, -1);
      fetch(32'h108, 0, -1);
      fetch(32'h10C, 0, -1);
      fetch(32'h100, 0, -1);
      fetch(32'h200, 0, -1);
      fetch(32'h100, 0, -1);
      fetch(32'h504, 1, -1);
      fetch(32'h508, 1, -1);
      fetch(32'h300, 0, 2);
      fetch(32'h300, 0, -1);
      fetch(32'h610, 2, 3);
      fetch(32'h614, 2, -1);
      idle_cycle();
      chk_stats();

      for (int i = 0; i < 250; i++) begin
         int r;
         r = $urandom_range(0, 11);
         pc = {22'd0, 2'($urandom), 3'($urandom),
               1'b0, 2'($urandom), 2'b00};
         if (r == 0) idle_cycle();
         else if (r == 1) inval_cycle();
         else fetch(pc, $urandom_range(0, 2),
                    ($urandom_range(0, 7) == 0) ?
                    $urandom_range(0, 3) : -1);
      end
      chk_stats();

      i_PC = 32'h400;
      i_Read = 1'b1;
      step();
      for (int b = 0; b < 2; b++) begin
         mem_if.i_Mem_Valid = 1'b1;
         mem_if.i_Mem_Data = memw(32'h400 + 32'(4 * b));
         step();
      end
      mem_if.i_Mem_Valid = 1'b0;
      chk("pre_rst_addr", mem_if.o_Mem_Addr, 32'h408);
      #2;
      i_Reset_n = 1'b0;
      #1;
      chk("midrst_req", mem_if.o_Mem_Req, 0);
      chk("midrst_addr", mem_if.o_Mem_Addr, 0);
      i_Read = 1'b0;
      #1;
      chk("midrst_miss", o_ICache_Miss, 0);
      m_hits = 0;
      m_misses = 0;
      model_clear();
      chk_stats();
      mem_if.i_Mem_Valid = 1'b1;
      @(negedge i_Clk);
      i_Reset_n = 1'b1;
      step();
      chk("postrst_req", mem_if.o_Mem_Req, 0);
      mem_if.i_Mem_Valid = 1'b0;
      fetch(32'h100, 0, -1);
      fetch(32'h10C, 0, -1);
      fetch(32'h400, 2, -1);
      fetch(32'h404, 0, -1);
      idle_cycle();
      chk_stats();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
